p4_router_drop_filter: RTL and testbench
========================================

# p4_router_drop_filter

Consumes the per-packet policer drop mark written into `vnp4_wrapper_metadata_t` by the P4 router policer and enforces it: marked packets are discarded whole, unmarked packets pass unchanged. Sits directly downstream of the policer in the ingress path, ahead of the congestion manager's queues. Keeps per-ingress-port pass/drop statistics.

## Interface
Parameters:
- `NUM_ING_PORTS`, 0 — number of ingress ports; must be > 0 (elab check).
- `CNT_WIDTH`, 32 — width of packet counters.
- `BYTE_CNT_WIDTH`, 48 — width of byte counters.

Ports:
- `clk`  in  1  — single clock for all logic; `packet_in.clk`/`packet_out.clk` are tied to it externally and not used.
- `sreset`  in  1  — synchronous, active-high reset; `sresetn` fields of the interfaces are ignored.
- `drop_enable`  in  NUM_ING_PORTS  — per-port enforcement; 0 = marked packets pass, mark left in metadata.
- `clear_counters`  in  1  — single-cycle pulse, zeroes all counters.
- `packet_in`  AXIS_int.Slave  — `tuser` is `vnp4_wrapper_metadata_t`.
- `packet_out`  AXIS_int.Master  — same DATA_BYTES as `packet_in` (elab check); `tuser` forwarded unchanged.
- `pass_pkt_count`  out  NUM_ING_PORTS×CNT_WIDTH  — packets forwarded.
- `drop_pkt_count`  out  NUM_ING_PORTS×CNT_WIDTH  — packets discarded.
- `drop_byte_count`  out  NUM_ING_PORTS×BYTE_CNT_WIDTH  — sum of `byte_length` of discarded packets.

## Operation
- SOP tracker: `sop` reg, reset 1; on every accepted input beat `sop <= tlast`.
- Decision taken on the SOP beat only: `drop_pkt = get_policer_drop_mark(tuser) && port < NUM_ING_PORTS && drop_enable[port]`. Latched in `dropping` for the remaining beats; metadata on non-SOP beats is ignored.
- States: PASS_IDLE (at SOP), PASS_BODY, DROP_BODY. SOP beat with drop → DROP_BODY unless tlast (stays at SOP); SOP beat pass → PASS_BODY unless tlast; tlast beat in either BODY → PASS_IDLE.
- Dropped beats: `packet_in.tready=1` unconditionally, beat discarded, output register untouched.
- Passed beats: one-stage output register; `packet_in.tready = !out_valid || packet_out.tready` while not dropping. All of tdata/tstrb/tkeep/tlast/tid/tdest/tuser copied.
- Counters updated on the tlast beat of a packet (drop or pass) using port/byte_length latched at SOP. Counters saturate at all-ones, no wrap.
- `ingress_port >= NUM_ING_PORTS`: packet forwarded (drop never applied), no counter updated.
- `clear_counters` same cycle as an increment: clear wins, that event is not counted.

## Timing
- Reset values: `packet_out.tvalid=0`, `tlast=0`, tdata/tid/tdest/tuser=0, tstrb/tkeep=all-ones, all counters 0, `sop=1`, state PASS_IDLE. `packet_in.tready` is 1 one cycle after reset deassert (output register empty).
- Latency: passed beat appears on `packet_out` the cycle after acceptance; full throughput (1 beat/clk) under no backpressure.
- Dropped packets consume 1 beat/clk regardless of `packet_out.tready`.
- `packet_out.tvalid` never deasserts without `tready`; payload stable while stalled (AXIS rules).
- Counter outputs update the cycle after the tlast beat is accepted.
- Reset mid-packet: state returns to PASS_IDLE; next accepted beat is treated as SOP (upstream resets together). In-flight output beat is lost.

## Structure
- `p4_router_pkg`: `get_policer_drop_mark()` (inverse of `add_policer_drop_mark_to_metadata()`), `vnp4_wrapper_metadata_t`, drop-filter state enum.
- One sub-module: `p4_router_sat_counter` (parameterized width, increment amount, clear, saturate), instantiated 3×NUM_ING_PORTS.

## Test plan
- NUM_ING_PORTS=4, 3-beat unmarked pkt port 2, `tready=1` → emerges 1 cycle later, bit-exact; pass_pkt_count[2]=1.
- 4-beat marked pkt port 1, byte_length=200, drop_enable=4'b1111 → no output beats, tready held 1; drop_pkt_count[1]=1, drop_byte_count[1]=200.
- Same marked pkt with drop_enable[1]=0 → forwarded with mark intact; pass_pkt_count[1]=1, drop counts 0.
- Back-to-back single-beat pkts drop/pass/drop/pass with random `packet_out.tready` → only pass pkts out, in order, no beat lost or duplicated.
- Force drop_pkt_count[0] to all-ones−1, drop 3 pkts → saturates at all-ones; clear_counters coincident with a drop → 0.
- Assert `sreset` mid-packet, then send new pkt → tvalid=0 during reset, new pkt treated from SOP and forwarded correctly.

Source files
------------

// File: rtl/p4_router_pkg.sv
// Shared P4 router types: wrapper metadata carried on AXIS tuser, policer mark helpers,
// and the drop-filter state encoding.
package p4_router_pkg;

    localparam int POLICER_DROP_BIT = 0;

    typedef struct packed {
        logic [7:0]  ingress_port;
        logic [7:0]  egress_port;
        logic [15:0] byte_length;
        logic [7:0]  flags;
    } vnp4_wrapper_metadata_t;

    typedef enum logic [1:0] {
        PASS_IDLE,
        PASS_BODY,
        DROP_BODY
    } drop_filter_state_t;

    function automatic vnp4_wrapper_metadata_t add_policer_drop_mark_to_metadata(
        input vnp4_wrapper_metadata_t md
    );
        vnp4_wrapper_metadata_t r;
        r = md;
        r.flags[POLICER_DROP_BIT] = 1'b1;
        return r;
    endfunction

    function automatic logic get_policer_drop_mark(input vnp4_wrapper_metadata_t md);
        return md.flags[POLICER_DROP_BIT];
    endfunction

endpackage

// File: rtl/axis_int.sv
// AXI4-Stream bundle; tuser defaults to the width of the P4 wrapper metadata.
// clk/sresetn travel with the bundle for blocks that take their clocking from it.
interface AXIS_int #(
    parameter int DATA_BYTES = 8,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = $bits(p4_router_pkg::vnp4_wrapper_metadata_t)
);
    logic                    clk;
    logic                    sresetn;
    logic                    tvalid;
    logic                    tready;
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tstrb;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport Master (input clk, sresetn, tready,
                    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser);
    modport Slave  (input clk, sresetn, tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
                    output tready);
endinterface

// File: rtl/p4_router_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
// Latency: count reflects an increment one cycle later; no flow control.
module p4_router_sat_counter #(
    parameter int WIDTH     = 32,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 sreset,
    input  logic                 clear,
    input  logic                 inc_en,
    input  logic [INC_WIDTH-1:0] inc_amt,
    output logic [WIDTH-1:0]     count
);
    logic [WIDTH:0] sum;

    assign sum = {1'b0, count} + (WIDTH+1)'(inc_amt);

    always_ff @(posedge clk) begin
        if (sreset || clear) begin
            count <= '0;
        end else if (inc_en) begin
            count <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/p4_router_drop_filter.sv
// Enforces the policer drop mark per packet and keeps per-port pass/drop statistics.
// Latency: 1 cycle for passed beats; dropped beats are sunk at 1 beat/clk ignoring output backpressure.
module p4_router_drop_filter
    import p4_router_pkg::*;
#(
    parameter int NUM_ING_PORTS  = 0,
    parameter int CNT_WIDTH      = 32,
    parameter int BYTE_CNT_WIDTH = 48
) (
    input  logic                                          clk,
    input  logic                                          sreset,
    input  logic [NUM_ING_PORTS-1:0]                      drop_enable,
    input  logic                                          clear_counters,
    AXIS_int.Slave                                        packet_in,
    AXIS_int.Master                                       packet_out,
    output logic [NUM_ING_PORTS-1:0][CNT_WIDTH-1:0]       pass_pkt_count,
    output logic [NUM_ING_PORTS-1:0][CNT_WIDTH-1:0]       drop_pkt_count,
    output logic [NUM_ING_PORTS-1:0][BYTE_CNT_WIDTH-1:0]  drop_byte_count
);
    generate
        if (NUM_ING_PORTS <= 0) begin : g_bad_num_ports
            $error("p4_router_drop_filter: NUM_ING_PORTS must be > 0");
        end
        if ($bits(packet_in.tdata) != $bits(packet_out.tdata)) begin : g_bad_data_width
            $error("p4_router_drop_filter: packet_in/packet_out DATA_BYTES differ");
        end
    endgenerate

    vnp4_wrapper_metadata_t in_md;
    drop_filter_state_t     state;
    logic                   sop;
    logic                   out_valid;
    logic                   en_sel;
    logic                   sop_port_ok;
    logic                   drop_pkt;
    logic                   drop_now;
    logic                   accept;
    logic                   eop;
    logic [7:0]             cur_port;
    logic [15:0]            cur_len;
    logic                   cur_port_ok;
    logic [7:0]             eop_port;
    logic [15:0]            eop_len;
    logic                   eop_port_ok;
    logic                   unused_if;

    assign in_md       = vnp4_wrapper_metadata_t'(packet_in.tuser);
    assign sop_port_ok = 32'(in_md.ingress_port) < NUM_ING_PORTS;

    always_comb begin
        en_sel = 1'b0;
        for (int i = 0; i < NUM_ING_PORTS; i++) begin
            if (32'(in_md.ingress_port) == i) en_sel = drop_enable[i];
        end
    end

    // Metadata is only trusted on the first beat; later beats follow the latched decision.
    assign drop_pkt = get_policer_drop_mark(in_md) && sop_port_ok && en_sel;
    assign drop_now = sop ? drop_pkt : (state == DROP_BODY);

    assign packet_in.tready = drop_now || !out_valid || packet_out.tready;
    assign accept           = packet_in.tvalid && packet_in.tready;
    assign eop              = accept && packet_in.tlast;

    assign eop_port    = sop ? in_md.ingress_port : cur_port;
    assign eop_len     = sop ? in_md.byte_length  : cur_len;
    assign eop_port_ok = sop ? sop_port_ok        : cur_port_ok;

    always_ff @(posedge clk) begin
        if (sreset) begin
            state       <= PASS_IDLE;
            sop         <= 1'b1;
            cur_port    <= '0;
            cur_len     <= '0;
            cur_port_ok <= 1'b0;
        end else if (accept) begin
            sop <= packet_in.tlast;
            if (sop) begin
                cur_port    <= in_md.ingress_port;
                cur_len     <= in_md.byte_length;
                cur_port_ok <= sop_port_ok;
            end
            case (state)
                PASS_IDLE: if (!packet_in.tlast) state <= drop_pkt ? DROP_BODY : PASS_BODY;
                default:   if (packet_in.tlast)  state <= PASS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            out_valid        <= 1'b0;
            packet_out.tdata <= '0;
            packet_out.tstrb <= '1;
            packet_out.tkeep <= '1;
            packet_out.tlast <= 1'b0;
            packet_out.tid   <= '0;
            packet_out.tdest <= '0;
            packet_out.tuser <= '0;
        end else if (accept && !drop_now) begin
            out_valid        <= 1'b1;
            packet_out.tdata <= packet_in.tdata;
            packet_out.tstrb <= packet_in.tstrb;
            packet_out.tkeep <= packet_in.tkeep;
            packet_out.tlast <= packet_in.tlast;
            packet_out.tid   <= packet_in.tid;
            packet_out.tdest <= packet_in.tdest;
            packet_out.tuser <= packet_in.tuser;
        end else if (packet_out.tready) begin
            out_valid <= 1'b0;
        end
    end

    assign packet_out.tvalid = out_valid;

    generate
        for (genvar p = 0; p < NUM_ING_PORTS; p++) begin : g_port
            logic hit;
            assign hit = eop && eop_port_ok && (32'(eop_port) == p);

            p4_router_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_pass_pkt (
                .clk(clk), .sreset(sreset), .clear(clear_counters),
                .inc_en(hit && !drop_now), .inc_amt(1'b1), .count(pass_pkt_count[p])
            );
            p4_router_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_drop_pkt (
                .clk(clk), .sreset(sreset), .clear(clear_counters),
                .inc_en(hit && drop_now), .inc_amt(1'b1), .count(drop_pkt_count[p])
            );
            p4_router_sat_counter #(.WIDTH(BYTE_CNT_WIDTH), .INC_WIDTH(16)) u_drop_byte (
                .clk(clk), .sreset(sreset), .clear(clear_counters),
                .inc_en(hit && drop_now), .inc_amt(eop_len), .count(drop_byte_count[p])
            );
        end
    endgenerate

    // Interface clock/reset are tied externally; only the block-level clk/sreset are used.
    assign unused_if = &{1'b0, packet_in.clk, packet_in.sresetn, packet_out.clk,
                         packet_out.sresetn, in_md.egress_port, in_md.flags};
endmodule

// File: tb/tb_p4_router_drop_filter.sv
// Directed bench for p4_router_drop_filter: 4 ports, 3-bit packet counters so saturation is reachable.
module tb_p4_router_drop_filter;
    import p4_router_pkg::*;

    localparam int NP   = 4;
    localparam int CW   = 3;
    localparam int BW   = 48;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [31:0]            data;
        vnp4_wrapper_metadata_t user;
        logic                   last;
        logic [3:0]             keep;
        logic [3:0]             strb;
        logic [3:0]             id;
        logic [3:0]             dest;
    } beat_t;

    logic                   clk;
    logic                   sreset;
    logic [NP-1:0]          drop_enable;
    logic                   clear_counters;
    logic [NP-1:0][CW-1:0]  pass_cnt;
    logic [NP-1:0][CW-1:0]  drop_cnt;
    logic [NP-1:0][BW-1:0]  dbyte_cnt;

    AXIS_int #(.DATA_BYTES(4)) in_if ();
    AXIS_int #(.DATA_BYTES(4)) out_if ();

    assign in_if.clk      = clk;
    assign out_if.clk     = clk;
    assign in_if.sresetn  = !sreset;
    assign out_if.sresetn = !sreset;

    p4_router_drop_filter #(
        .NUM_ING_PORTS(NP), .CNT_WIDTH(CW), .BYTE_CNT_WIDTH(BW)
    ) dut (
        .clk(clk), .sreset(sreset), .drop_enable(drop_enable), .clear_counters(clear_counters),
        .packet_in(in_if), .packet_out(out_if),
        .pass_pkt_count(pass_cnt), .drop_pkt_count(drop_cnt), .drop_byte_count(dbyte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     seq      = 0;
    int     drop_stalls;
    int     stall_viol = 0;
    bit     rand_rdy = 0;
    bit     hold_low = 0;
    beat_t  exp_q[$];
    beat_t  rcv_q[$];
    int     exp_pass[NP];
    int     exp_drop[NP];
    longint exp_db[NP];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        forever begin
            out_if.tready = hold_low ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            @(posedge clk);
            #1;
        end
    end

    beat_t prev_beat;
    bit    prev_stall = 0;
    always @(negedge clk) begin
        beat_t b;
        b.data = out_if.tdata;  b.user = vnp4_wrapper_metadata_t'(out_if.tuser);
        b.last = out_if.tlast;  b.keep = out_if.tkeep;  b.strb = out_if.tstrb;
        b.id   = out_if.tid;    b.dest = out_if.tdest;
        if (sreset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!out_if.tvalid || b != prev_beat)) stall_viol++;
            if (out_if.tvalid && out_if.tready) rcv_q.push_back(b);
            prev_stall = out_if.tvalid && !out_if.tready;
            prev_beat  = b;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input beat_t b, output int waited);
        waited = 0;
        in_if.tvalid = 1'b1;  in_if.tdata = b.data;  in_if.tuser = b.user;
        in_if.tlast  = b.last; in_if.tkeep = b.keep; in_if.tstrb = b.strb;
        in_if.tid    = b.id;   in_if.tdest = b.dest;
        @(negedge clk);
        while (!in_if.tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check_eq("in_tready_timeout", 64'(in_if.tready), 64'd1);
        step();
        in_if.tvalid = 1'b0;
    endtask

    // First beat carries the real mark; body beats carry the opposite mark, which must be ignored.
    task automatic send_pkt(input int port, input int nbeats, input bit mark, input int len);
        vnp4_wrapper_metadata_t md, md_m, sop_md, body_md;
        beat_t b;
        bit    drop;
        int    w;
        md = '0;
        md.ingress_port = 8'(port);
        md.egress_port  = 8'(seq);
        md.byte_length  = 16'(len);
        md_m    = add_policer_drop_mark_to_metadata(md);
        sop_md  = mark ? md_m : md;
        body_md = mark ? md : md_m;
        drop = mark && (port < NP) && drop_enable[port[1:0]];
        for (int i = 0; i < nbeats; i++) begin
            seq++;
            b.data = 32'hC0DE_0000 + 32'(seq);
            b.user = (i == 0) ? sop_md : body_md;
            b.last = (i == nbeats - 1);
            b.keep = b.last ? 4'h7 : 4'hF;
            b.strb = b.last ? 4'h3 : 4'hF;
            b.id   = 4'(port);
            b.dest = 4'(seq);
            send_beat(b, w);
            if (drop) drop_stalls += w;
            else      exp_q.push_back(b);
        end
        if (port < NP) begin
            if (drop) begin
                if (exp_drop[port] < CMAX) exp_drop[port]++;
                exp_db[port] += longint'(len);
            end else if (exp_pass[port] < CMAX) begin
                exp_pass[port]++;
            end
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < NP; i++) begin
            exp_pass[i] = 0; exp_drop[i] = 0; exp_db[i] = 0;
        end
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < NP; i++) begin
            check_eq($sformatf("%s pass_pkt_count[%0d]", tag, i), 64'(pass_cnt[i]), 64'(exp_pass[i]));
            check_eq($sformatf("%s drop_pkt_count[%0d]", tag, i), 64'(drop_cnt[i]), 64'(exp_drop[i]));
            check_eq($sformatf("%s drop_byte_count[%0d]", tag, i), 64'(dbyte_cnt[i]), 64'(exp_db[i]));
        end
    endtask

    task automatic compare_out(input string tag);
        int n;
        repeat (12) @(negedge clk);
        check_eq($sformatf("%s beat_count", tag), 64'(rcv_q.size()), 64'(exp_q.size()));
        n = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s tdata[%0d]", tag, i), 64'(rcv_q[i].data), 64'(exp_q[i].data));
            check_eq($sformatf("%s tuser[%0d]", tag, i), 64'(rcv_q[i].user), 64'(exp_q[i].user));
            check_eq($sformatf("%s ctrl[%0d]", tag, i),
                     64'({rcv_q[i].last, rcv_q[i].keep, rcv_q[i].strb, rcv_q[i].id, rcv_q[i].dest}),
                     64'({exp_q[i].last, exp_q[i].keep, exp_q[i].strb, exp_q[i].id, exp_q[i].dest}));
        end
        exp_q.delete();
        rcv_q.delete();
        step();
    endtask

    int    tbl[8][4] = '{'{0, 1, 1, 64}, '{3, 1, 0, 65}, '{2, 1, 1, 66}, '{3, 1, 0, 67},
                         '{5, 2, 1, 68}, '{1, 1, 1, 69}, '{0, 3, 0, 70}, '{2, 1, 1, 71}};
    beat_t mid;
    int    w0;

    initial begin
        sreset = 1'b1; drop_enable = 4'hF; clear_counters = 1'b0;
        in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tuser = '0; in_if.tlast = 1'b0;
        in_if.tkeep = '1; in_if.tstrb = '1; in_if.tid = '0; in_if.tdest = '0;
        zero_model();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset tvalid", 64'(out_if.tvalid), 64'd0);
        check_eq("reset tlast", 64'(out_if.tlast), 64'd0);
        check_eq("reset tkeep", 64'(out_if.tkeep), 64'hF);
        check_eq("reset tstrb", 64'(out_if.tstrb), 64'hF);
        check_eq("reset tdata", 64'(out_if.tdata), 64'd0);
        check_eq("reset tuser", 64'(out_if.tuser), 64'd0);
        check_counts("reset");
        step();
        sreset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("tready after reset", 64'(in_if.tready), 64'd1);
        step();

        // Unmarked 3-beat packet, port 2: last beat is on the output one cycle after acceptance
        send_pkt(2, 3, 1'b0, 96);
        check_eq("latency tvalid", 64'(out_if.tvalid), 64'd1);
        check_eq("latency tlast", 64'(out_if.tlast), 64'd1);
        check_eq("latency tdata", 64'(out_if.tdata), 64'(exp_q[2].data));
        check_counts("pass3");
        compare_out("pass3");

        // Marked 4-beat packet port 1 is sunk even while the output register is stalled
        hold_low = 1'b1;
        step();
        send_pkt(2, 1, 1'b0, 64);
        drop_stalls = 0;
        send_pkt(1, 4, 1'b1, 200);
        check_eq("drop tready held", 64'(drop_stalls), 64'd0);
        check_counts("drop4");
        hold_low = 1'b0;
        compare_out("drop4");

        // Enforcement disabled on port 1: forwarded with the mark intact
        drop_enable = 4'b1101;
        send_pkt(1, 4, 1'b1, 200);
        compare_out("nodrop");
        check_counts("nodrop");

        // Mixed drop/pass stream with random output backpressure (port 5 is out of range)
        drop_enable = 4'hF;
        rand_rdy = 1'b1;
        foreach (tbl[k]) send_pkt(tbl[k][0], tbl[k][1], tbl[k][2] != 0, tbl[k][3]);
        rand_rdy = 1'b0;
        compare_out("mixed");
        check_counts("mixed");

        // Saturation of drop_pkt_count[0]
        while (exp_drop[0] < CMAX - 1) send_pkt(0, 1, 1'b1, 10);
        check_eq("drop_cnt0 near sat", 64'(drop_cnt[0]), 64'(CMAX - 1));
        repeat (3) send_pkt(0, 1, 1'b1, 10);
        check_eq("drop_cnt0 saturated", 64'(drop_cnt[0]), 64'(CMAX));
        check_counts("sat");

        // Clear coincident with a counted drop: clear wins
        clear_counters = 1'b1;
        send_pkt(0, 1, 1'b1, 50);
        clear_counters = 1'b0;
        zero_model();
        check_counts("clear");
        send_pkt(3, 1, 1'b1, 40);
        check_counts("after clear");
        compare_out("clear");

        // Reset mid-packet with a stalled output beat, then a droppable and a passing packet
        hold_low = 1'b1;
        step();
        mid.data = 32'hDEAD_BEEF; mid.user = '0; mid.user.ingress_port = 8'd2;
        mid.last = 1'b0; mid.keep = 4'hF; mid.strb = 4'hF; mid.id = 4'd2; mid.dest = 4'd0;
        send_beat(mid, w0);
        sreset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("tvalid in reset", 64'(out_if.tvalid), 64'd0);
        step();
        sreset = 1'b0;
        hold_low = 1'b0;
        exp_q.delete();
        rcv_q.delete();
        zero_model();
        step();
        send_pkt(1, 4, 1'b1, 120);
        send_pkt(3, 2, 1'b0, 80);
        compare_out("post reset");
        check_counts("post reset");

        check_eq("axis stall stability", 64'(stall_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
